// File: rtl/ioread_pkg.sv
// Shared types and select-decode helpers for the ioread hub.
package ioread_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  // Helpers take a widened select vector so any channel count up to MAX_CH works.
  localparam int MAX_CH    = 64;
  localparam int MAX_IDX_W = 6;

  function automatic logic onehot_valid(input logic [MAX_CH-1:0] cs);
    logic [MAX_CH-1:0] one;
    one = {{(MAX_CH-1){1'b0}}, 1'b1};
    return (cs != '0) && ((cs & (cs - one)) == '0);
  endfunction

  function automatic logic [MAX_IDX_W-1:0] onehot_to_idx(input logic [MAX_CH-1:0] cs);
    logic [MAX_IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_CH; i++) begin
      if (cs[i]) idx = i[MAX_IDX_W-1:0];
    end
    return idx;
  endfunction

endpackage

// File: rtl/ioread_sync.sv
// Multi-stage flop synchroniser for one peripheral data channel.
module ioread_sync #(
  parameter int DATA_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] stage_q [SYNC_STAGES];
  logic [DATA_W-1:0] stage_d [SYNC_STAGES];

  always_comb begin
    stage_d[0] = d;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < SYNC_STAGES; i++) begin
      if (reset) stage_q[i] <= '0;
      else       stage_q[i] <= stage_d[i];
    end
  end

  assign q = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/ioread_hub.sv
// Multi-channel synchronised read port with per-channel wait states,
// serving one read per ior strobe to memorio.
module ioread_hub
  import ioread_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int N_CH        = 4,
  parameter int SYNC_STAGES = 2,
  parameter int WAIT_W      = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ior,
  input  logic [N_CH-1:0]          cs,
  input  logic [N_CH*WAIT_W-1:0]   ch_wait,
  input  logic [N_CH*DATA_W-1:0]   ch_data,
  output logic [DATA_W-1:0]        ioread_data,
  output logic                     ioread_valid,
  output logic                     ioread_err,
  output logic                     busy,
  output logic                     drop
);

  localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic [DATA_W-1:0] sync_data [N_CH];
  logic [WAIT_W-1:0] wait_arr  [N_CH];

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    ioread_sync #(
      .DATA_W      (DATA_W),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (ch_data[g*DATA_W +: DATA_W]),
      .q     (sync_data[g])
    );
    assign wait_arr[g] = ch_wait[g*WAIT_W +: WAIT_W];
  end

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] cnt_q,   cnt_d;
  logic [IDX_W-1:0]  ch_q,    ch_d;
  logic [DATA_W-1:0] data_q,  data_d;
  logic              valid_q, valid_d;
  logic              err_q,   err_d;
  logic              drop_q,  drop_d;

  logic [MAX_CH-1:0]    cs_ext;
  logic [MAX_IDX_W-1:0] idx_full;
  logic [IDX_W-1:0]     sel_idx;
  logic                 sel_ok;

  always_comb begin
    cs_ext           = '0;
    cs_ext[N_CH-1:0] = cs;
    sel_ok           = onehot_valid(cs_ext);
    idx_full         = onehot_to_idx(cs_ext);
    sel_idx          = idx_full[IDX_W-1:0];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ch_d    = ch_q;
    data_d  = data_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    drop_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (ior) begin
          if (sel_ok) begin
            ch_d  = sel_idx;
            cnt_d = wait_arr[sel_idx];
            if (wait_arr[sel_idx] == '0) begin
              data_d  = sync_data[sel_idx];
              valid_d = 1'b1;
            end else begin
              state_d = WAIT;
            end
          end else begin
            // Bad select still completes so memorio is never left waiting.
            data_d  = '0;
            valid_d = 1'b1;
            err_d   = 1'b1;
          end
        end
      end
      WAIT: begin
        drop_d = ior;
        if (cnt_q == WAIT_W'(1)) begin
          data_d  = sync_data[ch_q];
          valid_d = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - WAIT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ch_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ch_q    <= ch_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      drop_q  <= drop_d;
    end
  end

  assign ioread_data  = data_q;
  assign ioread_valid = valid_q;
  assign ioread_err   = err_q;
  assign drop         = drop_q;
  assign busy         = (state_q == WAIT);

endmodule
